// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use / multi-cycle multiply / branch-flush pipeline hazard control
// Optional stall-cycle performance counter enabled by defining HAZARD_CTRL_PERF_CNT_EN.
module hazard_control_unit #(
  parameter int MUL_LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  IF_ID_RsAddr_i,
  input  logic [4:0]  IF_ID_RtAddr_i,
  input  logic        ID_EX_MemRead_i,
  input  logic [4:0]  ID_EX_RtAddr_i,
  input  logic        ID_IsMul_i,
  input  logic        Branch_Taken_i,
  output logic        PCWrite_o,
  output logic        IF_ID_Write_o,
  output logic        IF_ID_Flush_o,
  output logic        ID_EX_Bubble_o,
  output logic        Mul_Start_o,
  output logic        Mul_Busy_o,
  output logic [15:0] Stall_Cnt_o
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MUL_WAIT = 1'b1;
  localparam logic [3:0] CNT_INIT    = 4'(MUL_LATENCY - 2);

  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;
  logic       stall;
  logic       flush;
  logic       start;

  always_comb begin
    load_use = ID_EX_MemRead_i && (ID_EX_RtAddr_i != 5'd0) &&
               ((ID_EX_RtAddr_i == IF_ID_RsAddr_i) || (ID_EX_RtAddr_i == IF_ID_RtAddr_i));
  end

  // Priority: load-use stall, then multiply start, then branch flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    start   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (load_use) begin
          stall = 1'b1;
        end else if (ID_IsMul_i) begin
          stall   = 1'b1;
          start   = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = ST_MUL_WAIT;
        end else begin
          flush = Branch_Taken_i;
        end
      end
      ST_MUL_WAIT: begin
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced to their reset values combinationally while rst_i is low.
  always_comb begin
    PCWrite_o      = rst_i && !stall;
    IF_ID_Write_o  = rst_i && !stall;
    ID_EX_Bubble_o = !rst_i || stall;
    IF_ID_Flush_o  = rst_i && flush;
    Mul_Start_o    = rst_i && start;
    Mul_Busy_o     = rst_i && (state_q == ST_MUL_WAIT) && (cnt_q != 4'd0);
  end

`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Cnt_o = stall_cnt_q;
`else
  assign Stall_Cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed scoreboard bench for hazard_control_unit
// Expected Stall_Cnt_o follows HAZARD_CTRL_PERF_CNT_EN.
module tb_hazard_control_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs, rt, ex_rt;
  logic        mem_rd, is_mul, br;
  logic        pc_w, ifid_w, flush, bubble, mstart, mbusy;
  logic [15:0] stall_cnt;

  // Expected vector order: {PCWrite, IF_ID_Write, Flush, Bubble, Mul_Start, Mul_Busy}
  localparam logic [5:0] E_RUN   = 6'b110000;
  localparam logic [5:0] E_STALL = 6'b000100;
  localparam logic [5:0] E_START = 6'b000110;
  localparam logic [5:0] E_BUSY  = 6'b000101;
  localparam logic [5:0] E_FLUSH = 6'b111000;
  localparam logic [5:0] E_RST   = 6'b000100;

  logic [5:0]  exp_q[$];
  logic [15:0] cnt_q[$];
  string       tag_q[$];
  int          n_cmp;
  int          n_bad;
  int          stall_model;

  hazard_control_unit #(.MUL_LATENCY(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .IF_ID_RsAddr_i  (rs),
    .IF_ID_RtAddr_i  (rt),
    .ID_EX_MemRead_i (mem_rd),
    .ID_EX_RtAddr_i  (ex_rt),
    .ID_IsMul_i      (is_mul),
    .Branch_Taken_i  (br),
    .PCWrite_o       (pc_w),
    .IF_ID_Write_o   (ifid_w),
    .IF_ID_Flush_o   (flush),
    .ID_EX_Bubble_o  (bubble),
    .Mul_Start_o     (mstart),
    .Mul_Busy_o      (mbusy),
    .Stall_Cnt_o     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out();
    logic [5:0]  obs;
    logic [5:0]  e;
    logic [15:0] c;
    string       t;
    obs = {pc_w, ifid_w, flush, bubble, mstart, mbusy};
    e = exp_q.pop_front();
    c = cnt_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", t, obs, e);
    end
    n_cmp++;
    assert (stall_cnt === c) else begin
      n_bad++;
      $error("FAIL %s_cnt: observed %0d expected %0d", t, stall_cnt, c);
    end
  endtask

  task automatic step(input logic rstv, input logic [4:0] rs_v, input logic [4:0] rt_v,
                      input logic mr_v, input logic [4:0] ert_v, input logic mul_v,
                      input logic br_v, input logic [5:0] e, input string tag);
    rst_n  = rstv;
    rs     = rs_v;
    rt     = rt_v;
    mem_rd = mr_v;
    ex_rt  = ert_v;
    is_mul = mul_v;
    br     = br_v;
    if (!rstv) stall_model = 0;
    exp_q.push_back(e);
`ifdef HAZARD_CTRL_PERF_CNT_EN
    cnt_q.push_back(16'(stall_model));
`else
    cnt_q.push_back(16'h0000);
`endif
    tag_q.push_back(tag);
    @(negedge clk);
    check_out();
    if (rstv && !e[5]) stall_model++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    stall_model = 0;
    //    rst  rs     rt     mr   ert    mul   br    expected  tag
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_RST,   "reset0");
    step(1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, E_RST,   "reset1");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, E_RUN,   "idle");
    step(1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0, E_STALL, "lu_rs");
    step(1'b1, 5'd5, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, E_RUN,   "lu_rs_after");
    step(1'b1, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, E_STALL, "lu_rt");
    step(1'b1, 5'd0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, E_RUN,   "lu_zero");
    step(1'b1, 5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, E_RUN,   "no_load");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, E_FLUSH, "br_only");
    step(1'b1, 5'd6, 5'd2, 1'b1, 5'd6, 1'b0, 1'b1, E_STALL, "br_lu");
    step(1'b1, 5'd6, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, E_FLUSH, "br_after_lu");
    // First multiply, held high with a branch that must be ignored while waiting
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_START, "mul1_c0");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, E_BUSY,  "mul1_c1");
    step(1'b1, 5'd1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b0, E_BUSY,  "mul1_c2");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, E_RUN,   "mul1_c3");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, E_RUN,   "mul1_post");
    // Load-use outranks multiply start
    step(1'b1, 5'd3, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, E_STALL, "lu_over_mul");
    step(1'b1, 5'd3, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_START, "mul2_c0");
    step(1'b1, 5'd3, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_BUSY,  "mul2_c1");
    step(1'b1, 5'd3, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_BUSY,  "mul2_c2");
    step(1'b1, 5'd3, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_RUN,   "mul2_c3");
    // Back-to-back multiply restarts a full sequence
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_START, "mul3_c0");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_BUSY,  "mul3_c1");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_BUSY,  "mul3_c2");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, E_RUN,   "mul3_c3");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, E_FLUSH, "br_post_mul");
    // Reset in the middle of a multiply wait
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_START, "mul4_c0");
    step(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, E_RST,   "mul4_rst");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_START, "mul5_c0");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_BUSY,  "mul5_c1");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_BUSY,  "mul5_c2");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, E_RUN,   "mul5_c3");
    step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, E_RUN,   "final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
